fp_pack: RTL and testbench

- Multi-cycle normalize/round/pack unit: inverse of the operand decomposer.
- Takes sign, signed biased exponent, extended mantissa with guard/round/sticky bits, and special-case flags.
- Emits an IEEE-754 single-precision word plus exception flags.
- Sits at the tail of the FPU add/sub datapath; valid/ready handshake on both sides.

---
 rtl/fp_pkg.sv | 27 ++
 rtl/fp_pack_if.sv | 32 +++
 rtl/fp_round.sv | 18 +
 rtl/fp_pack.sv | 141 ++++++++++++++
 tb/tb_fp_pack.sv | 185 ++++++++++++++++++
 5 files changed

// File: rtl/fp_pkg.sv
// Shared floating-point constants, state encoding and packed-word layout.
// Also used by the operand decomposer.
package fp_pkg;

  localparam int BIAS    = 127;
  localparam int SIGN_W  = 1;
  localparam int EXP_F_W = 8;
  localparam int FRAC_W  = 23;

  localparam logic [EXP_F_W-1:0] EXP_MAX = 8'hFF;
  localparam logic [31:0]        QNAN    = 32'h7FC0_0000;

  typedef enum logic [2:0] {
    IDLE,
    NORM,
    DENORM,
    ROUND,
    DONE
  } fp_state_e;

  typedef struct packed {
    logic [SIGN_W-1:0]  sign;
    logic [EXP_F_W-1:0] exp;
    logic [FRAC_W-1:0]  frac;
  } fp_word_t;

endpackage

// File: rtl/fp_pack_if.sv
// Handshake and data bundle for the pack stage.
// master = upstream/downstream side, slave = the pack unit.
interface fp_pack_if #(
  parameter int EXP_W  = 10,
  parameter int MANT_W = 28
) ();

  logic                    in_valid_i;
  logic                    in_ready_o;
  logic                    sign_i;
  logic signed [EXP_W-1:0] exp_i;
  logic [MANT_W-1:0]       mant_i;
  logic                    nan_i;
  logic                    inf_i;
  logic                    out_valid_o;
  logic                    out_ready_i;
  logic [31:0]             result_o;
  logic                    overflow_o;
  logic                    underflow_o;
  logic                    inexact_o;

  modport master (
    output in_valid_i, sign_i, exp_i, mant_i, nan_i, inf_i, out_ready_i,
    input  in_ready_o, out_valid_o, result_o, overflow_o, underflow_o, inexact_o
  );

  modport slave (
    input  in_valid_i, sign_i, exp_i, mant_i, nan_i, inf_i, out_ready_i,
    output in_ready_o, out_valid_o, result_o, overflow_o, underflow_o, inexact_o
  );

endinterface

// File: rtl/fp_round.sv
// Combinational round-to-nearest-even incrementer on the 24-bit significand.
module fp_round (
  input  logic [23:0] sig,
  input  logic        guard,
  input  logic        rnd,
  input  logic        sticky,
  output logic [23:0] rounded,
  output logic        carry,
  output logic        inexact
);

  logic inc;

  assign inc              = guard & (rnd | sticky | sig[0]);
  assign {carry, rounded} = {1'b0, sig} + {24'd0, inc};
  assign inexact          = guard | rnd | sticky;

endmodule

// File: rtl/fp_pack.sv
// Normalize/round/pack to IEEE-754 single. Subnormal output is produced when
// FP_PACK_DENORM_EN is defined; otherwise tiny results flush to signed zero.
module fp_pack
  import fp_pkg::*;
#(
  parameter int MANT_W = 28,
  parameter int EXP_W  = 10
) (
  input  logic     clk_i,
  input  logic     rst_ni,
  fp_pack_if.slave bus
);

  // IDLE capture | NORM shift to 1.x | DENORM subnormal/flush | ROUND RNE+pack | DONE hold
  localparam logic signed [EXP_W-1:0] EXP_ONE = EXP_W'(1);
  localparam logic signed [EXP_W-1:0] EXP_OVF = EXP_W'(255);

  fp_state_e               st;
  logic                    sgn;
  logic signed [EXP_W-1:0] exp_q;
  logic [MANT_W-1:0]       mant_q;
  fp_word_t                res_q;
  logic                    ovf_q;
  logic                    unf_q;
  logic                    inx_q;

  logic [FRAC_W:0]         rnd_sig;
  logic                    rnd_carry;
  logic                    rnd_inexact;
  logic [FRAC_W-1:0]       frac_n;
  logic                    hidden_n;
  logic signed [EXP_W-1:0] exp_n;

  fp_round u_round (
    .sig     (mant_q[MANT_W-2:3]),
    .guard   (mant_q[2]),
    .rnd     (mant_q[1]),
    .sticky  (mant_q[0]),
    .rounded (rnd_sig),
    .carry   (rnd_carry),
    .inexact (rnd_inexact)
  );

  always_comb begin
    frac_n   = rnd_carry ? rnd_sig[FRAC_W:1] : rnd_sig[FRAC_W-1:0];
    hidden_n = rnd_carry | rnd_sig[FRAC_W];
    exp_n    = exp_q + EXP_W'(rnd_carry);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      st     <= IDLE;
      sgn    <= 1'b0;
      exp_q  <= '0;
      mant_q <= '0;
      res_q  <= '0;
      ovf_q  <= 1'b0;
      unf_q  <= 1'b0;
      inx_q  <= 1'b0;
    end else begin
      case (st)
        IDLE: begin
          if (bus.in_valid_i) begin
            sgn    <= bus.sign_i;
            exp_q  <= bus.exp_i;
            mant_q <= bus.mant_i;
            if (bus.nan_i) begin
              res_q <= fp_word_t'(QNAN);
              st    <= DONE;
            end else if (bus.inf_i) begin
              res_q <= '{sign: bus.sign_i, exp: EXP_MAX, frac: '0};
              st    <= DONE;
            end else begin
              st <= NORM;
            end
          end
        end
        NORM: begin
          if (mant_q == '0) begin
            res_q <= '{sign: sgn, exp: '0, frac: '0};
            st    <= DONE;
          end else if (mant_q[MANT_W-1]) begin
            mant_q <= {1'b0, mant_q[MANT_W-1:2], mant_q[1] | mant_q[0]};
            exp_q  <= exp_q + EXP_ONE;
          end else if (!mant_q[MANT_W-2]) begin
            mant_q <= mant_q << 1;
            exp_q  <= exp_q - EXP_ONE;
          end else if (exp_q < EXP_ONE) begin
            st <= DENORM;
          end else begin
            st <= ROUND;
          end
        end
        DENORM: begin
          unf_q <= 1'b1;
`ifdef FP_PACK_DENORM_EN
          if (exp_q < EXP_ONE) begin
            mant_q <= {1'b0, mant_q[MANT_W-1:2], mant_q[1] | mant_q[0]};
            exp_q  <= exp_q + EXP_ONE;
          end else begin
            st <= ROUND;
          end
`else
          res_q <= '{sign: sgn, exp: '0, frac: '0};
          inx_q <= |mant_q;
          st    <= DONE;
`endif
        end
        ROUND: begin
          if (exp_n >= EXP_OVF) begin
            res_q <= '{sign: sgn, exp: EXP_MAX, frac: '0};
            ovf_q <= 1'b1;
            inx_q <= 1'b1;
          end else begin
            // A clear hidden bit here means the value stayed subnormal.
            res_q <= '{sign: sgn, exp: hidden_n ? exp_n[EXP_F_W-1:0] : '0, frac: frac_n};
            inx_q <= rnd_inexact;
          end
          st <= DONE;
        end
        DONE: begin
          if (bus.out_ready_i) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
            inx_q <= 1'b0;
            st    <= IDLE;
          end
        end
        default: st <= IDLE;
      endcase
    end
  end

  assign bus.in_ready_o  = (st == IDLE);
  assign bus.out_valid_o = (st == DONE);
  assign bus.result_o    = res_q;
  assign bus.overflow_o  = ovf_q;
  assign bus.underflow_o = unf_q;
  assign bus.inexact_o   = inx_q;

endmodule

// File: tb/tb_fp_pack.sv
// Directed bench for fp_pack: results, flags, latency, handshake hold and reset abort.
module tb_fp_pack;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   passed = 0;

  always #5 clk = ~clk;

  fp_pack_if #(.EXP_W(10), .MANT_W(28)) bus ();

  fp_pack #(.MANT_W(28), .EXP_W(10)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  // Present one operand, then count edges after the accepting edge until valid.
  task automatic run_op(input logic s, input logic signed [9:0] e, input logic [27:0] m,
                        input logic n, input logic i, output int lat);
    @(posedge clk); #1;
    bus.sign_i = s; bus.exp_i = e; bus.mant_i = m; bus.nan_i = n; bus.inf_i = i;
    bus.in_valid_i = 1'b1;
    @(posedge clk); #1;
    bus.in_valid_i = 1'b0;
    lat = 0;
    while (!bus.out_valid_o && lat < 600) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic take_result();
    bus.out_ready_i = 1'b1;
    @(posedge clk); #1;
    bus.out_ready_i = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    total++; if (bus.in_ready_o !== 1'b1) $display("FAIL rst_in_ready got %b exp 1", bus.in_ready_o); else passed++;
    total++; if (bus.out_valid_o !== 1'b0) $display("FAIL rst_out_valid got %b exp 0", bus.out_valid_o); else passed++;
    total++; if (bus.result_o !== 32'h0) $display("FAIL rst_result got %h exp 00000000", bus.result_o); else passed++;
    total++; if ({bus.overflow_o, bus.underflow_o, bus.inexact_o} !== 3'b000)
      $display("FAIL rst_flags got %b exp 000", {bus.overflow_o, bus.underflow_o, bus.inexact_o}); else passed++;
    #20 rst_n = 1'b1;
  endtask

  task automatic test_normal();
    int lat;
    run_op(1'b0, 10'sd127, 28'h1 << 26, 1'b0, 1'b0, lat);
    total++; if (lat !== 2) $display("FAIL norm_latency got %0d exp 2", lat); else passed++;
    total++; if (bus.result_o !== 32'h3F800000) $display("FAIL norm_result got %h exp 3f800000", bus.result_o); else passed++;
    total++; if ({bus.overflow_o, bus.underflow_o, bus.inexact_o} !== 3'b000)
      $display("FAIL norm_flags got %b exp 000", {bus.overflow_o, bus.underflow_o, bus.inexact_o}); else passed++;
    take_result();
    total++; if (bus.out_valid_o !== 1'b0 || bus.in_ready_o !== 1'b1)
      $display("FAIL norm_release got valid=%b ready=%b exp valid=0 ready=1", bus.out_valid_o, bus.in_ready_o); else passed++;
  endtask

  task automatic test_carry();
    int lat;
    run_op(1'b0, 10'sd127, 28'h1 << 27, 1'b0, 1'b0, lat);
    total++; if (lat !== 3) $display("FAIL carry_latency got %0d exp 3", lat); else passed++;
    total++; if (bus.result_o !== 32'h40000000) $display("FAIL carry_result got %h exp 40000000", bus.result_o); else passed++;
    take_result();
  endtask

  task automatic test_left_shift();
    int lat;
    run_op(1'b0, 10'sd133, 28'h1 << 20, 1'b0, 1'b0, lat);
    total++; if (lat !== 8) $display("FAIL lshift_latency got %0d exp 8", lat); else passed++;
    total++; if (bus.result_o !== 32'h3F800000) $display("FAIL lshift_result got %h exp 3f800000", bus.result_o); else passed++;
    take_result();
  endtask

  task automatic test_round_ties();
    int lat;
    run_op(1'b0, 10'sd127, (28'h1 << 26) | (28'h1 << 2), 1'b0, 1'b0, lat);
    total++; if (bus.result_o !== 32'h3F800000) $display("FAIL tie_even_result got %h exp 3f800000", bus.result_o); else passed++;
    total++; if (bus.inexact_o !== 1'b1) $display("FAIL tie_even_inexact got %b exp 1", bus.inexact_o); else passed++;
    take_result();
    total++; if (bus.inexact_o !== 1'b0) $display("FAIL flag_clear got %b exp 0", bus.inexact_o); else passed++;
    run_op(1'b0, 10'sd127, (28'h1 << 26) | (28'h1 << 3) | (28'h1 << 2), 1'b0, 1'b0, lat);
    total++; if (bus.result_o !== 32'h3F800002) $display("FAIL tie_odd_result got %h exp 3f800002", bus.result_o); else passed++;
    total++; if (bus.inexact_o !== 1'b1) $display("FAIL tie_odd_inexact got %b exp 1", bus.inexact_o); else passed++;
    take_result();
  endtask

  task automatic test_overflow();
    int lat;
    run_op(1'b0, 10'sd255, 28'h1 << 26, 1'b0, 1'b0, lat);
    total++; if (bus.result_o !== 32'h7F800000) $display("FAIL ovf_result got %h exp 7f800000", bus.result_o); else passed++;
    total++; if ({bus.overflow_o, bus.underflow_o, bus.inexact_o} !== 3'b101)
      $display("FAIL ovf_flags got %b exp 101", {bus.overflow_o, bus.underflow_o, bus.inexact_o}); else passed++;
    take_result();
  endtask

  task automatic test_underflow();
    int lat;
    logic [31:0] exp_res;
    logic        exp_inx;
    int          exp_lat;
`ifdef FP_PACK_DENORM_EN
    exp_res = 32'h80400000; exp_inx = 1'b0; exp_lat = 4;
`else
    exp_res = 32'h80000000; exp_inx = 1'b1; exp_lat = 2;
`endif
    run_op(1'b1, 10'sd0, 28'h1 << 26, 1'b0, 1'b0, lat);
    total++; if (lat !== exp_lat) $display("FAIL unf_latency got %0d exp %0d", lat, exp_lat); else passed++;
    total++; if (bus.result_o !== exp_res) $display("FAIL unf_result got %h exp %h", bus.result_o, exp_res); else passed++;
    total++; if (bus.underflow_o !== 1'b1) $display("FAIL unf_flag got %b exp 1", bus.underflow_o); else passed++;
    total++; if (bus.inexact_o !== exp_inx) $display("FAIL unf_inexact got %b exp %b", bus.inexact_o, exp_inx); else passed++;
    take_result();
  endtask

  task automatic test_specials();
    int lat;
    run_op(1'b1, 10'sd5, 28'h0, 1'b1, 1'b1, lat);
    total++; if (lat !== 0) $display("FAIL nan_latency got %0d exp 0", lat); else passed++;
    total++; if (bus.result_o !== 32'h7FC00000) $display("FAIL nan_result got %h exp 7fc00000", bus.result_o); else passed++;
    take_result();
    run_op(1'b1, 10'sd5, 28'h0, 1'b0, 1'b1, lat);
    total++; if (bus.result_o !== 32'hFF800000) $display("FAIL inf_result got %h exp ff800000", bus.result_o); else passed++;
    take_result();
    run_op(1'b1, 10'sd100, 28'h0, 1'b0, 1'b0, lat);
    total++; if (bus.result_o !== 32'h80000000) $display("FAIL zero_result got %h exp 80000000", bus.result_o); else passed++;
    total++; if ({bus.overflow_o, bus.underflow_o, bus.inexact_o} !== 3'b000)
      $display("FAIL zero_flags got %b exp 000", {bus.overflow_o, bus.underflow_o, bus.inexact_o}); else passed++;
    take_result();
  endtask

  task automatic test_hold();
    int lat;
    run_op(1'b0, 10'sd127, (28'h1 << 26) | (28'h1 << 3) | (28'h1 << 2), 1'b0, 1'b0, lat);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      total++;
      if (bus.out_valid_o !== 1'b1 || bus.in_ready_o !== 1'b0 || bus.result_o !== 32'h3F800002 ||
          {bus.overflow_o, bus.underflow_o, bus.inexact_o} !== 3'b001)
        $display("FAIL hold_%0d got v=%b r=%b res=%h fl=%b exp v=1 r=0 res=3f800002 fl=001", k,
                 bus.out_valid_o, bus.in_ready_o, bus.result_o, {bus.overflow_o, bus.underflow_o, bus.inexact_o});
      else passed++;
    end
    take_result();
  endtask

  task automatic test_reset_mid();
    @(posedge clk); #1;
    bus.sign_i = 1'b0; bus.exp_i = 10'sd133; bus.mant_i = 28'h1 << 20; bus.nan_i = 1'b0; bus.inf_i = 1'b0;
    bus.in_valid_i = 1'b1;
    @(posedge clk); #1;
    bus.in_valid_i = 1'b0;
    @(posedge clk); #1;
    total++; if (bus.in_ready_o !== 1'b0) $display("FAIL mid_busy got %b exp 0", bus.in_ready_o); else passed++;
    rst_n = 1'b0;
    #1;
    total++; if (bus.in_ready_o !== 1'b1 || bus.out_valid_o !== 1'b0)
      $display("FAIL mid_reset got ready=%b valid=%b exp ready=1 valid=0", bus.in_ready_o, bus.out_valid_o); else passed++;
    #2 rst_n = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      total++; if (bus.out_valid_o !== 1'b0) $display("FAIL mid_no_output cycle %0d got %b exp 0", k, bus.out_valid_o); else passed++;
    end
  endtask

  initial begin
    bus.in_valid_i = 1'b0; bus.sign_i = 1'b0; bus.exp_i = '0; bus.mant_i = '0;
    bus.nan_i = 1'b0; bus.inf_i = 1'b0; bus.out_ready_i = 1'b0;
    test_reset();
    test_normal();
    test_carry();
    test_left_shift();
    test_round_ties();
    test_overflow();
    test_underflow();
    test_specials();
    test_hold();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
